// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
// Shared definitions for the register-file write-port arbiter:
//   - default register data/address widths and register count
//   - wb_req_t : one buffered write (destination register + data)
//   - wb_src_e : marks whether the output register holds a pipeline or a
//                FIFO-sourced write (needed for the pending-register mask)
package wb_arb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_REGS = 2 ** DEF_ADDR_W;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_PIPE = 1'b0,
    SRC_FIFO = 1'b1
  } wb_src_e;

endpackage : wb_arb_pkg

// File: rtl/wb_fifo.sv
// wb_fifo
// Synchronous circular buffer for long-latency write-back results.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   push_i/push_addr_i/_data_i  enqueue request (ignored when full)
//   pop_i                    dequeue the head (ignored when empty)
//   head_addr_o/head_data_o  current head entry
//   count_o, full_o, empty_o occupancy, all derived from registered state
//   valid_o, entry_addr_o    per-slot valid bits and packed slot addresses
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [ADDR_W-1:0]       push_addr_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  output logic [ADDR_W-1:0]       head_addr_o,
  output logic [DATA_W-1:0]       head_data_o,
  output logic [CNT_W-1:0]        count_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [DEPTH-1:0]        valid_o,
  output logic [DEPTH*ADDR_W-1:0] entry_addr_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == CNT_W'(0));
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign count_o     = count_q;
  assign valid_o     = valid_q;

  // Flatten slot addresses for the pending-mask reduction in the top level.
  always_comb begin
    entry_addr_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr_o[i*ADDR_W +: ADDR_W] = addr_q[i];
    end
  end

  // Pointer, occupancy and valid-bit next state; pointers wrap at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (do_pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset (flushes the buffer).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage; contents are qualified by valid_q so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : wb_fifo

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between the in-order WB path and an
// out-of-band long-latency unit. Long-latency results wait in a small FIFO
// and drain into idle WB slots; after STARVE_LIMIT consecutive pipeline wins
// with a non-empty FIFO, the pipeline is stalled for one cycle.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   pipe_wen/pipe_addr/pipe_data       pipeline write request
//   pipe_stall                         pipeline must hold WB inputs
//   lu_valid/lu_addr/lu_data, lu_ready long-latency result handshake
//   rf_wen/rf_addr/rf_data             registered register-file write
//   pend_mask                          registers with an outstanding LU write
//   fifo_count                         buffer occupancy
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int NUM_REGS    = 2 ** ADDR_W,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1),
  localparam int SC_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pipe_wen,
  input  logic [ADDR_W-1:0]   pipe_addr,
  input  logic [DATA_W-1:0]   pipe_data,
  output logic                pipe_stall,
  input  logic                lu_valid,
  output logic                lu_ready,
  input  logic [ADDR_W-1:0]   lu_addr,
  input  logic [DATA_W-1:0]   lu_data,
  output logic                rf_wen,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_data,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic [CNT_W-1:0]    fifo_count
);

  logic [ADDR_W-1:0]            head_addr_s;
  logic [DATA_W-1:0]            head_data_s;
  logic                         fifo_full_s, fifo_empty_s;
  logic [FIFO_DEPTH-1:0]        fifo_valid_s;
  logic [FIFO_DEPTH*ADDR_W-1:0] fifo_entry_addr_s;
  logic                         force_s, pipe_grant_s, fifo_grant_s, push_s;

  logic [SC_W-1:0]   starve_q, starve_d;
  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  wb_src_e           src_q, src_d;

  // Force depends only on flops so pipe_stall has no input-to-output loop
  // other than the final AND with pipe_wen.
  assign force_s      = !fifo_empty_s && (starve_q == SC_W'(STARVE_LIMIT));
  assign pipe_stall   = pipe_wen && force_s;
  assign pipe_grant_s = pipe_wen && !force_s;
  assign fifo_grant_s = !pipe_grant_s && !fifo_empty_s;

  // Ready comes from the registered count: a same-cycle pop does not help.
  assign lu_ready = !fifo_full_s;
  assign push_s   = lu_valid && lu_ready;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push_s),
    .push_addr_i  (lu_addr),
    .push_data_i  (lu_data),
    .pop_i        (fifo_grant_s),
    .head_addr_o  (head_addr_s),
    .head_data_o  (head_data_s),
    .count_o      (fifo_count),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s),
    .valid_o      (fifo_valid_s),
    .entry_addr_o (fifo_entry_addr_s)
  );

  // Grant selection, output-register next state and starvation counter.
  always_comb begin
    rf_wen_d  = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    src_d     = SRC_PIPE;
    starve_d  = starve_q;
    if (pipe_grant_s) begin
      rf_wen_d  = 1'b1;
      rf_addr_d = pipe_addr;
      rf_data_d = pipe_data;
      src_d     = SRC_PIPE;
    end else if (fifo_grant_s) begin
      rf_wen_d  = 1'b1;
      rf_addr_d = head_addr_s;
      rf_data_d = head_data_s;
      src_d     = SRC_FIFO;
    end else begin
      rf_wen_d  = 1'b0;
    end
    if (fifo_empty_s || fifo_grant_s) begin
      starve_d = '0;
    end else if (pipe_grant_s && (starve_q != SC_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SC_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Output register and starvation counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen_q  <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      src_q     <= SRC_PIPE;
      starve_q  <= '0;
    end else begin
      rf_wen_q  <= rf_wen_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      src_q     <= src_d;
      starve_q  <= starve_d;
    end
  end

  assign rf_wen  = rf_wen_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;

  // Pending mask: every buffered destination, plus the output register while
  // it carries a FIFO-sourced write that has not reached the RF yet.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid_s[i]) begin
        pend_mask[fifo_entry_addr_s[i*ADDR_W +: ADDR_W]] = 1'b1;
      end else begin
        pend_mask = pend_mask;
      end
    end
    if (rf_wen_q && (src_q == SRC_FIFO)) begin
      pend_mask[rf_addr_q] = 1'b1;
    end else begin
      pend_mask = pend_mask;
    end
  end

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a queue-based reference model
// is compared against the DUT every cycle, plus directed literal checks.
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int NR    = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_wen;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          pipe_stall;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          rf_wen;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [NR-1:0] pend_mask;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wen(pipe_wen), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_data(rf_data),
    .pend_mask(pend_mask), .fifo_count(fifo_count)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  // Reference model state
  ent_t          mq[$];
  int            m_starve = 0;
  logic          m_wen = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit            m_from_fifo = 1'b0;
  bit            m_live = 1'b0;

  always @(posedge clk) begin : model
    bit had, frc, rdy;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_starve = 0; m_wen = 1'b0; m_addr = '0; m_data = '0;
      m_from_fifo = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      had = (mq.size() != 0);
      frc = had && (m_starve == LIMIT);
      rdy = (mq.size() < DEPTH);
      if (pipe_wen && !frc) begin
        m_wen = 1'b1; m_addr = pipe_addr; m_data = pipe_data; m_from_fifo = 1'b0;
        m_starve = had ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else if (had) begin
        e = mq.pop_front();
        m_wen = 1'b1; m_addr = e.addr; m_data = e.data; m_from_fifo = 1'b1;
        m_starve = 0;
      end else begin
        m_wen = 1'b0; m_from_fifo = 1'b0; m_starve = 0;
      end
      if (lu_valid && rdy) mq.push_back('{lu_addr, lu_data});
    end
  end

  always @(negedge clk) begin : compare
    logic [NR-1:0] ep;
    if (m_live) begin
      ep = '0;
      foreach (mq[i]) ep[mq[i].addr] = 1'b1;
      if (m_wen && m_from_fifo) ep[m_addr] = 1'b1;
      chk("pipe_stall", pipe_stall, pipe_wen && (mq.size() != 0) && (m_starve == LIMIT));
      chk("lu_ready", lu_ready, mq.size() < DEPTH);
      chk("rf_wen", rf_wen, m_wen);
      chk("rf_addr", rf_addr, m_addr);
      chk("rf_data", rf_data, m_data);
      chk("pend_mask", pend_mask, ep);
      chk("fifo_count", fifo_count, mq.size());
      chk("decode_rule", pipe_wen && pend_mask[pipe_addr], 1'b0);
    end
  end

  // Stimulus helpers
  ent_t          lu_q[$];
  bit            pipe_on = 1'b0;
  bit            pipe_held = 1'b0;
  bit            last_stall = 1'b0;
  int            pipe_seq = 0;
  logic [AW-1:0] saved_addr;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit acc;
      ent_t e;
      if (pipe_on) begin
        if (!pipe_held) begin
          pipe_addr = AW'(1 + pipe_seq % 5);
          pipe_data = 32'hA500_0000 + DW'(pipe_seq);
          pipe_seq++;
        end
        pipe_wen = 1'b1;
      end else begin
        pipe_wen = 1'b0;
      end
      if (!lu_valid && lu_q.size() != 0) begin
        e = lu_q.pop_front();
        lu_valid = 1'b1; lu_addr = e.addr; lu_data = e.data;
      end
      #1;
      last_stall = pipe_stall;
      pipe_held  = pipe_wen && pipe_stall;
      acc        = lu_valid && lu_ready;
      @(posedge clk); #2;
      if (acc) lu_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; pipe_wen = 1'b0; pipe_addr = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_pend", pend_mask, 16'h0000);
    chk("rst_ready", lu_ready, 1'b1);
    chk("rst_count", fifo_count, 2'd0);
    rst_n = 1'b1;
    run(3);

    // Pipeline-only write
    pipe_wen = 1'b1; pipe_addr = 4'd3; pipe_data = 32'hDEADBEEF;
    #1; chk("t1_stall", pipe_stall, 1'b0);
    @(posedge clk); #2;
    pipe_wen = 1'b0;
    chk("t1_wen", rf_wen, 1'b1);
    chk("t1_addr", rf_addr, 4'd3);
    chk("t1_data", rf_data, 32'hDEADBEEF);
    chk("t1_pend", pend_mask, 16'h0000);
    run(2);

    // Idle drain
    lu_q.push_back('{4'd7, 32'h12});
    run(1);
    chk("t2_pend_acc", pend_mask, 16'h0080);
    chk("t2_wen_acc", rf_wen, 1'b0);
    run(1);
    chk("t2_wen", rf_wen, 1'b1);
    chk("t2_addr", rf_addr, 4'd7);
    chk("t2_data", rf_data, 32'h12);
    chk("t2_pend_out", pend_mask, 16'h0080);
    run(1);
    chk("t2_wen_off", rf_wen, 1'b0);
    chk("t2_pend_clr", pend_mask, 16'h0000);

    // Full FIFO with pipeline busy; third result waits for the first pop
    pipe_on = 1'b1;
    lu_q.push_back('{4'd8, 32'h80});
    lu_q.push_back('{4'd9, 32'h90});
    lu_q.push_back('{4'd10, 32'hA0});
    run(2);
    chk("t3_count_full", fifo_count, 2'd2);
    chk("t3_not_ready", lu_ready, 1'b0);
    run(3);
    chk("t3_still_full", fifo_count, 2'd2);
    chk("t3_held_valid", lu_valid, 1'b1);
    run(1);
    chk("t3_pop_addr", rf_addr, 4'd8);
    chk("t3_pop_data", rf_data, 32'h80);
    chk("t3_count_after_pop", fifo_count, 2'd1);
    run(1);
    chk("t3_third_accepted", fifo_count, 2'd2);
    run(12);
    pipe_on = 1'b0;
    run(4);
    chk("t3_drained", fifo_count, 2'd0);

    // Starvation guard
    pipe_on = 1'b1;
    lu_q.push_back('{4'd11, 32'hB0});
    run(1);
    for (int k = 0; k < 7; k++) begin
      run(1);
      chk($sformatf("t4_stall_%0d", k), last_stall, (k == 4));
      if (k == 4) begin
        saved_addr = pipe_addr;
        chk("t4_fifo_addr", rf_addr, 4'd11);
        chk("t4_fifo_data", rf_data, 32'hB0);
      end
      if (k == 5) begin
        chk("t4_stalled_lands", rf_addr, saved_addr);
        chk("t4_pend_clear", pend_mask, 16'h0000);
      end
    end
    pipe_on = 1'b0;
    run(2);

    // Simultaneous push and pop at count 1
    lu_q.push_back('{4'd7, 32'h71});
    lu_q.push_back('{4'd8, 32'h81});
    run(1);
    chk("t5_count1", fifo_count, 2'd1);
    run(1);
    chk("t5_count_same", fifo_count, 2'd1);
    chk("t5_first_addr", rf_addr, 4'd7);
    chk("t5_first_data", rf_data, 32'h71);
    run(1);
    chk("t5_second_addr", rf_addr, 4'd8);
    chk("t5_second_data", rf_data, 32'h81);
    chk("t5_empty", fifo_count, 2'd0);
    run(1);

    // Reset mid-drain
    pipe_on = 1'b1;
    lu_q.push_back('{4'd9, 32'h91});
    lu_q.push_back('{4'd10, 32'hA1});
    run(2);
    chk("t6_count_full", fifo_count, 2'd2);
    pipe_on = 1'b0;
    rst_n = 1'b0;
    run(1);
    chk("t6_rst_wen", rf_wen, 1'b0);
    chk("t6_rst_addr", rf_addr, 4'd0);
    chk("t6_rst_data", rf_data, 32'h0);
    chk("t6_rst_pend", pend_mask, 16'h0000);
    chk("t6_rst_ready", lu_ready, 1'b1);
    chk("t6_rst_count", fifo_count, 2'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run(1);
      chk("t6_no_stale_wen", rf_wen, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_wb_port_arbiter

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline write-back path and a variable-latency unit (multiply/divide or load-miss return) that completes out of band. Long-latency results are buffered in a small FIFO and drained into idle write-back slots, with a starvation guard that briefly stalls the pipeline. The block sits between the WB stage output and the register file, and exports a pending-register mask that decode uses as a scoreboard.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
- FIFO_DEPTH, 2, long-latency result buffer entries (≥1)
- STARVE_LIMIT, 4, consecutive pipeline wins tolerated while the FIFO is non-empty (≥1)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset
- pipe_wen  in  1  pipeline WB write request
- pipe_addr  in  ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline write data
- pipe_stall  out  1  pipeline must hold its WB inputs this cycle
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept
- lu_addr  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result
- rf_wen  out  1  RF write enable (registered)
- rf_addr  out  ADDR_W  RF write address (registered)
- rf_data  out  DATA_W  RF write data (registered)
- pend_mask  out  NUM_REGS  bit r set if a long-latency write to r is in the FIFO or in the output register
- fifo_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

## Operation
- force = (fifo_count != 0) && (starve_cnt == STARVE_LIMIT); depends only on flops.
- pipe_stall = pipe_wen && force (combinational).
- Grant each cycle:
  - pipe_wen && !force: pipeline granted; output reg ← {1, pipe_addr, pipe_data}.
  - Otherwise, if the FIFO is non-empty: head popped; output reg ← {1, head.addr, head.data}.
  - Otherwise: rf_wen ← 0. rf_addr/rf_data hold their previous values.
- starve_cnt: +1 (saturating at STARVE_LIMIT) when the pipeline is granted while the FIFO is non-empty. Cleared on any FIFO grant and whenever the FIFO is empty.
- lu_ready = (fifo_count < FIFO_DEPTH), from registered count only. A pop in the same cycle does not raise ready.
- Push when lu_valid && lu_ready. lu_addr/lu_data must stay stable while lu_valid && !lu_ready.
- Simultaneous push and pop: both happen and count is unchanged.
- No bypass: a pushed entry is poppable from the next cycle.
- pend_mask = OR of one-hot(addr) over valid FIFO entries, OR one-hot(rf_addr) if the output register currently holds a FIFO-sourced write. Duplicate addresses are allowed.
- Protocol rule: decode never issues a pipeline write to a register whose pend_mask bit is set. The bench asserts this; the block does not check it.
- Reset (rst_n=0 at an edge, including mid-drain): FIFO flushed, fifo_count=0, starve_cnt=0, rf_wen=0, rf_addr=0, rf_data=0. After reset, pend_mask=0, lu_ready=1 and pipe_stall=0.

## Timing
- Pipeline write granted in cycle t → rf_wen=1 in cycle t+1.
- Long-latency result accepted in cycle t → rf_wen=1 no earlier than t+2.
- Stalled pipeline write (pipe_stall=1 in cycle t) is granted in t+1, because starve_cnt has cleared.
- Worst-case FIFO head wait with continuous pipeline writes: STARVE_LIMIT+1 cycles.
- FIFO order is strict FIFO; no reordering among long-latency results.

## Structure
- Package wb_arb_pkg:
  - DATA_W, ADDR_W, NUM_REGS defaults.
  - wb_req_t struct {addr, data}.
  - Flag marking a FIFO-sourced output.
- Sub-module wb_fifo:
  - Synchronous circular FIFO of wb_req_t, depth FIFO_DEPTH.
  - Ports: push/pop, head, count, full.
  - Per-entry valid and addr vectors exported for pend_mask.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Top level holds the grant logic, starve_cnt, output register and pend_mask OR-reduction.

## Test plan
- Pipeline only: pipe_wen=1, addr=3, data=0xDEADBEEF in cycle 5 → rf_wen=1, rf_addr=3, rf_data=0xDEADBEEF in cycle 6. pipe_stall=0 and pend_mask=0 throughout.
- Idle drain: lu push addr=7, data=0x12 with pipe_wen=0.
  - pend_mask[7]=1 next cycle.
  - rf write of 0x12 to r7 two cycles after accept.
  - pend_mask[7] clears the cycle after that.
- Full FIFO: two pushes with pipe_wen held at 1 → lu_ready=0 and fifo_count=2. A third lu_valid is held until the first pop; the data is then accepted in order.
- Starvation: FIFO holds 1 entry and pipe_wen=1 continuously with STARVE_LIMIT=4.
  - Four pipeline writes occur.
  - Then pipe_stall=1 for exactly one cycle, the FIFO entry is written, and the stalled pipeline write lands the next cycle.
- Simultaneous push/pop at count=1 with pipe_wen=0 → count stays 1 and order is preserved.
- Reset mid-drain: FIFO at count=2 and rst_n=0 for one edge → all outputs 0, pend_mask=0, lu_ready=1, and no stale rf_wen after release.
